// File: rtl/decode_pipe.sv
// RV32I decode stage: registered decode with valid/ready handshake, multi-source forwarding,
// load-use stall detection, write-through register file and a saturating stall counter.

package decode_pipe_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_NOP
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic              valid;
        logic              rd_we;
        logic [REG_W-1:0]  rd_s;
        logic [DATA_W-1:0] rd_v;
    } wb_id_t;

    typedef struct packed {
        logic              valid;
        logic [ILEN-1:0]   pc;
        logic [REG_W-1:0]  rd_s;
        logic [REG_W-1:0]  rs1_s;
        logic [REG_W-1:0]  rs2_s;
        logic [DATA_W-1:0] rs1_v;
        logic [DATA_W-1:0] rs2_v;
        logic [ILEN-1:0]   imm;
        alu_op_e           alu_op;
        logic [2:0]        funct3;
        logic              use_imm;
        logic              rd_we;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic              is_jump;
    } id_ex_t;
endpackage

module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = DATA_W,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  if_id_t                    if_id_i,
    output logic                      id_ready_o,
    input  logic                      ex_ready_i,
    output id_ex_t                    id_ex_o,
    output logic                      illegal_o,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD-1:0]        fwd_rd_we_i,
    input  logic [NUM_FWD-1:0]        fwd_is_load_i,
    input  logic [NUM_FWD*REG_W-1:0]  fwd_rd_s_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_rd_v_i,
    input  wb_id_t                    wb_id_i,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    logic [XLEN-1:0]             rf_q [32];
    logic [1:0][REG_W-1:0]       rs_s;
    logic [1:0][XLEN-1:0]        rs_v;
    logic [1:0]                  rs_stall;
    id_ex_t                      dec;
    logic                        dec_illegal;
    logic                        out_free_c;
    logic                        hazard_c;
    id_ex_t                      id_ex_d, id_ex_q;
    logic                        illegal_d, illegal_q;
    logic [CNT_W-1:0]            stall_cnt_d, stall_cnt_q;

    assign rs_s[0] = if_id_i.instr[19:15];
    assign rs_s[1] = if_id_i.instr[24:20];

    // Register file; x0 never written.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_id_i.valid && wb_id_i.rd_we && wb_id_i.rd_s != '0) begin
            rf_q[wb_id_i.rd_s] <= wb_id_i.rd_v;
        end
    end

    // Operand resolution: youngest matching source wins, then WB bypass, then regfile.
    always_comb begin
        rs_v     = '0;
        rs_stall = '0;
        for (int n = 0; n < 2; n++) begin
            rs_v[n] = rf_q[rs_s[n]];
            if (wb_id_i.valid && wb_id_i.rd_we && wb_id_i.rd_s == rs_s[n]) begin
                rs_v[n] = wb_id_i.rd_v;
            end
            for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
                if (fwd_valid_i[k] && fwd_rd_we_i[k] && fwd_rd_s_i[k*REG_W +: REG_W] == rs_s[n]) begin
                    rs_v[n]     = fwd_rd_v_i[k*XLEN +: XLEN];
                    rs_stall[n] = fwd_is_load_i[k];
                end
            end
            if (rs_s[n] == '0) begin
                rs_v[n]     = '0;
                rs_stall[n] = 1'b0;
            end
        end
    end

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Instruction decode.
    always_comb begin
        logic [ILEN-1:0] ins;
        ins             = if_id_i.instr;
        dec             = '0;
        dec.alu_op      = ALU_NOP;
        dec_illegal     = 1'b0;
        dec.valid       = if_id_i.valid;
        dec.pc          = if_id_i.pc;
        dec.rd_s        = ins[11:7];
        dec.rs1_s       = rs_s[0];
        dec.rs2_s       = rs_s[1];
        dec.rs1_v       = rs_v[0];
        dec.rs2_v       = rs_v[1];
        dec.funct3      = ins[14:12];
        case (ins[6:0])
            OPC_LUI: begin
                dec.rd_we = 1'b1; dec.use_imm = 1'b1; dec.alu_op = ALU_PASSB;
                dec.imm   = {ins[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.rd_we = 1'b1; dec.use_imm = 1'b1; dec.alu_op = ALU_ADD;
                dec.imm   = {ins[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.rd_we = 1'b1; dec.use_imm = 1'b1; dec.is_jump = 1'b1; dec.alu_op = ALU_ADD;
                dec.imm   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec.rd_we = 1'b1; dec.use_imm = 1'b1; dec.is_jump = 1'b1; dec.alu_op = ALU_ADD;
                dec.imm   = {{20{ins[31]}}, ins[31:20]};
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1; dec.alu_op = ALU_SUB;
                dec.imm       = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OPC_LOAD: begin
                dec.rd_we = 1'b1; dec.use_imm = 1'b1; dec.is_load = 1'b1; dec.alu_op = ALU_ADD;
                dec.imm   = {{20{ins[31]}}, ins[31:20]};
            end
            OPC_STORE: begin
                dec.use_imm = 1'b1; dec.is_store = 1'b1; dec.alu_op = ALU_ADD;
                dec.imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OPC_OP_IMM: begin
                dec.rd_we = 1'b1; dec.use_imm = 1'b1;
                dec.alu_op = alu_from_f3(ins[14:12], ins[30] && ins[14:12] == 3'b101);
                dec.imm    = {{20{ins[31]}}, ins[31:20]};
            end
            OPC_OP: begin
                dec.rd_we  = 1'b1;
                dec.alu_op = alu_from_f3(ins[14:12], ins[30]);
            end
            OPC_FENCE: begin
                dec.alu_op = ALU_NOP;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign out_free_c = !id_ex_q.valid || ex_ready_i;
    assign hazard_c   = |rs_stall;
    assign id_ready_o = flush_i || (out_free_c && !hazard_c);

    // Output register next state: flush, bubble, capture or hold.
    always_comb begin
        id_ex_d     = id_ex_q;
        illegal_d   = illegal_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            id_ex_d.valid = 1'b0;
            illegal_d     = 1'b0;
        end else if (out_free_c && hazard_c && if_id_i.valid) begin
            id_ex_d.valid = 1'b0;
            illegal_d     = 1'b0;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (out_free_c) begin
            id_ex_d   = dec;
            illegal_d = dec_illegal && if_id_i.valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_ex_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_ex_o     = id_ex_q;
    assign illegal_o   = illegal_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
